// File: rtl/endian_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// endian_ctrl_pkg
// Shared definitions for the endian_stream_ctrl byte-to-word sequencer:
//   - sequencer state encoding
//   - default lane geometry (byte width, lanes per word)
//   - lane-counter width and statistics-counter widths
// -----------------------------------------------------------------------------
package endian_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no packet in progress
        ACCUM = 2'd1,   // lanes being filled
        STALL = 2'd2    // complete word parked, output register occupied
    } state_e;

    localparam int DEF_BYTE_SIZE   = 8;
    localparam int DEF_INPUT_BYTES = 4;
    localparam int LANE_CNT_W      = $clog2(DEF_INPUT_BYTES);

    localparam int PKT_CNT_W  = 16;
    localparam int WORD_CNT_W = 32;

endpackage

// File: rtl/endian_switch.sv
// -----------------------------------------------------------------------------
// endian_switch
// Purely combinational lane reversal: lane i of the input appears in lane
// INPUT_BYTES-1-i of the output. Used with BYTE_SIZE=1 to reverse keep bits.
// Ports:
//   in_data   [INPUT_BYTES*BYTE_SIZE]  word in
//   out_data  [INPUT_BYTES*BYTE_SIZE]  word with lane order reversed
// -----------------------------------------------------------------------------
module endian_switch #(
    parameter int BYTE_SIZE   = 8,
    parameter int INPUT_BYTES = 4
) (
    input  logic [INPUT_BYTES*BYTE_SIZE-1:0] in_data,
    output logic [INPUT_BYTES*BYTE_SIZE-1:0] out_data
);

    always_comb begin
        out_data = '0;
        for (int i = 0; i < INPUT_BYTES; i++) begin
            out_data[i*BYTE_SIZE +: BYTE_SIZE] =
                in_data[(INPUT_BYTES-1-i)*BYTE_SIZE +: BYTE_SIZE];
        end
    end

endmodule

// File: rtl/endian_stream_ctrl.sv
// -----------------------------------------------------------------------------
// endian_stream_ctrl
// Packs a one-byte-per-cycle stream into INPUT_BYTES-wide words, optionally
// reversing byte order per packet, and presents words on a valid/ready port.
// Optional statistics counters are built when ENDIAN_CTRL_STATS_EN is defined.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   s_data/s_valid/
//   s_ready/s_last       byte input stream
//   swap_en              byte-order select, latched on a packet's first byte
//   m_data/m_keep/
//   m_valid/m_ready/
//   m_last               word output stream
//   pkt_count            completed packets   (ENDIAN_CTRL_STATS_EN only)
//   word_count           transferred words   (ENDIAN_CTRL_STATS_EN only)
// -----------------------------------------------------------------------------
module endian_stream_ctrl
    import endian_ctrl_pkg::*;
#(
    parameter int BYTE_SIZE   = DEF_BYTE_SIZE,
    parameter int INPUT_BYTES = DEF_INPUT_BYTES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [BYTE_SIZE-1:0]             s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic                             s_last,
    input  logic                             swap_en,
    output logic [INPUT_BYTES*BYTE_SIZE-1:0] m_data,
    output logic [INPUT_BYTES-1:0]           m_keep,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic                             m_last
`ifdef ENDIAN_CTRL_STATS_EN
    ,
    output logic [PKT_CNT_W-1:0]             pkt_count,
    output logic [WORD_CNT_W-1:0]            word_count
`endif
);

    localparam int LANE_W = $clog2(INPUT_BYTES);
    localparam int WORD_W = INPUT_BYTES * BYTE_SIZE;

    state_e                 state_q, state_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [WORD_W-1:0]      acc_data_q, acc_data_d;
    logic [INPUT_BYTES-1:0] acc_keep_q, acc_keep_d;
    logic                   acc_last_q, acc_last_d;
    logic                   swap_q, swap_d;
    logic [WORD_W-1:0]      m_data_q, m_data_d;
    logic [INPUT_BYTES-1:0] m_keep_q, m_keep_d;
    logic                   m_last_q, m_last_d;
    logic                   m_valid_q, m_valid_d;

    logic                   hs_in, out_hs, out_free, last_lane, load_out;
    logic [WORD_W-1:0]      word_data, src_data, swp_data, out_data;
    logic [INPUT_BYTES-1:0] word_keep, src_keep, swp_keep, out_keep;
    logic                   src_swap;

    // s_ready depends only on registered state, never on m_ready.
    assign s_ready   = (state_q != STALL);
    assign hs_in     = s_valid & s_ready;
    assign out_hs    = m_valid_q & m_ready;
    assign out_free  = ~m_valid_q | m_ready;
    assign last_lane = (lane_q == LANE_W'(INPUT_BYTES-1));

    // Accumulator with the incoming byte merged into the current lane;
    // lane 0 is the most significant byte in straight order.
    always_comb begin
        word_data = acc_data_q;
        word_keep = acc_keep_q;
        for (int i = 0; i < INPUT_BYTES; i++) begin
            if (lane_q == LANE_W'(i)) begin
                word_data[(INPUT_BYTES-1-i)*BYTE_SIZE +: BYTE_SIZE] = s_data;
                word_keep[INPUT_BYTES-1-i] = 1'b1;
            end
        end
    end

    // Word heading to the output register: the parked word when leaving
    // STALL, otherwise the word being completed this cycle. In IDLE the first
    // byte's swap_en applies directly since swap_q is not yet loaded.
    assign src_data = (state_q == STALL) ? acc_data_q : word_data;
    assign src_keep = (state_q == STALL) ? acc_keep_q : word_keep;
    assign src_swap = (state_q == IDLE)  ? swap_en    : swap_q;

    endian_switch #(
        .BYTE_SIZE  (BYTE_SIZE),
        .INPUT_BYTES(INPUT_BYTES)
    ) u_data_switch (
        .in_data (src_data),
        .out_data(swp_data)
    );

    endian_switch #(
        .BYTE_SIZE  (1),
        .INPUT_BYTES(INPUT_BYTES)
    ) u_keep_switch (
        .in_data (src_keep),
        .out_data(swp_keep)
    );

    assign out_data = src_swap ? swp_data : src_data;
    assign out_keep = src_swap ? swp_keep : src_keep;

    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        acc_last_d = acc_last_q;
        swap_d     = swap_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_last_d   = m_last_q;
        m_valid_d  = m_valid_q & ~m_ready;
        load_out   = 1'b0;

        case (state_q)
            IDLE, ACCUM: begin
                if (hs_in) begin
                    if (state_q == IDLE) begin
                        swap_d = swap_en;
                    end
                    if (s_last || last_lane) begin
                        lane_d = '0;
                        if (out_free) begin
                            load_out   = 1'b1;
                            acc_data_d = '0;
                            acc_keep_d = '0;
                            state_d    = s_last ? IDLE : ACCUM;
                        end else begin
                            acc_data_d = word_data;
                            acc_keep_d = word_keep;
                            acc_last_d = s_last;
                            state_d    = STALL;
                        end
                    end else begin
                        acc_data_d = word_data;
                        acc_keep_d = word_keep;
                        lane_d     = lane_q + LANE_W'(1);
                        state_d    = ACCUM;
                    end
                end
            end
            STALL: begin
                // m_valid_q is always set here, so m_ready is a handshake.
                if (m_ready) begin
                    load_out   = 1'b1;
                    acc_data_d = '0;
                    acc_keep_d = '0;
                    acc_last_d = 1'b0;
                    state_d    = acc_last_q ? IDLE : ACCUM;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_out) begin
            m_data_d  = out_data;
            m_keep_d  = out_keep;
            m_last_d  = (state_q == STALL) ? acc_last_q : s_last;
            m_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
            acc_last_q <= 1'b0;
            swap_q     <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            acc_last_q <= acc_last_d;
            swap_q     <= swap_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_last_q   <= m_last_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;
    assign m_valid = m_valid_q;

`ifdef ENDIAN_CTRL_STATS_EN
    logic [PKT_CNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic [WORD_CNT_W-1:0] word_count_q, word_count_d;

    always_comb begin
        pkt_count_d  = pkt_count_q;
        word_count_d = word_count_q;
        if (out_hs) begin
            word_count_d = word_count_q + WORD_CNT_W'(1);
            if (m_last_q) begin
                pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            pkt_count_q  <= pkt_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign word_count = word_count_q;
`else
    // out_hs only feeds the statistics counters.
    logic unused_out_hs;
    assign unused_out_hs = out_hs;
`endif

endmodule

// File: tb/tb_endian_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_endian_stream_ctrl
// Directed bench for endian_stream_ctrl. Expected words are pushed into a
// queue before the bytes are driven; a negedge monitor compares every
// presented word against the queue head and pops on handshake.
// Statistics checks are built when ENDIAN_CTRL_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_endian_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last = 1'b0;
    logic        swap_en = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
`ifdef ENDIAN_CTRL_STATS_EN
    logic [15:0] pkt_count;
    logic [31:0] word_count;
`endif

    endian_stream_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .swap_en   (swap_en),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
`ifdef ENDIAN_CTRL_STATS_EN
        ,
        .pkt_count (pkt_count),
        .word_count(word_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    // Drives one byte and returns #1 after its handshake edge, so consecutive
    // calls stream one byte per cycle.
    task automatic send_byte(input logic [7:0] d, input logic last, input logic sw);
        int n = 0;
        s_data  = d;
        s_last  = last;
        swap_en = sw;
        s_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ready && n < 200);
        if (!s_ready) begin
            check("send_timeout", 64'(s_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented word must match the queue head; it pops when
    // the handshake will complete on the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("m_data", 64'(m_data), 64'(exp_q[0].data));
                    check("m_keep", 64'(m_keep), 64'(exp_q[0].keep));
                    check("m_last", 64'(m_last), 64'(exp_q[0].last));
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_keep", 64'(m_keep), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: full word, no swap, plus one-cycle latency.
        expect_word(32'h11223344, 4'hF, 1'b1);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_latency", 64'(m_valid), 64'd1);
        wait_drain();
        check("t1_valid_clear", 64'(m_valid), 64'd0);
        check("t1_data_hold", 64'(m_data), 64'h11223344);

        // 2: full word, swap.
        expect_word(32'h44332211, 4'hF, 1'b1);
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b1);
        send_byte(8'h33, 1'b0, 1'b1);
        send_byte(8'h44, 1'b1, 1'b1);
        wait_drain();

        // 3: partial last word, both orders, back-to-back packets.
        expect_word(32'hAABBCCDD, 4'hF, 1'b0);
        expect_word(32'hEEFF0000, 4'hC, 1'b1);
        expect_word(32'hDDCCBBAA, 4'hF, 1'b0);
        expect_word(32'h0000FFEE, 4'h3, 1'b1);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 6; i++) begin
                send_byte(8'hAA + 8'(i * 8'h11), (i == 5), (p == 1));
            end
        end
        wait_drain();
`ifdef ENDIAN_CTRL_STATS_EN
        check("stats_pkt", 64'(pkt_count), 64'd4);
        check("stats_word", 64'(word_count), 64'd6);
`endif

        // 4: backpressure; second word parks and s_ready drops.
        m_ready = 1'b0;
        expect_word(32'h01020304, 4'hF, 1'b0);
        expect_word(32'h05060708, 4'hF, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), (i == 8), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_s_ready_low", 64'(s_ready), 64'd0);
            check("t4_data_stable", 64'(m_data), 64'h01020304);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_valid_kept", 64'(m_valid), 64'd1);
        check("t4_s_ready_back", 64'(s_ready), 64'd1);
        wait_drain();

        // 5: swap_en change mid-packet is ignored; next packet swaps.
        expect_word(32'h10111213, 4'hF, 1'b0);
        expect_word(32'h14151617, 4'hF, 1'b1);
        expect_word(32'h24232221, 4'hF, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h10 + 8'(i), (i == 7), (i != 0));
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h21 + 8'(i), (i == 3), 1'b1);
        end
        wait_drain();

        // Single-byte packets in both orders.
        expect_word(32'h5A000000, 4'h8, 1'b1);
        expect_word(32'h000000A5, 4'h1, 1'b1);
        send_byte(8'h5A, 1'b1, 1'b0);
        send_byte(8'hA5, 1'b1, 1'b1);
        wait_drain();

        // 6: reset mid-packet discards the partial word.
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'h66, 1'b0, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_m_valid", 64'(m_valid), 64'd0);
        check("t6_m_data", 64'(m_data), 64'd0);
        check("t6_m_keep", 64'(m_keep), 64'd0);
        check("t6_m_last", 64'(m_last), 64'd0);
        check("t6_s_ready", 64'(s_ready), 64'd1);
`ifdef ENDIAN_CTRL_STATS_EN
        check("t6_pkt_rst", 64'(pkt_count), 64'd0);
        check("t6_word_rst", 64'(word_count), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_word(32'h11223344, 4'hF, 1'b1);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        wait_drain();
        repeat (3) @(posedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/endian_stream_ctrl.md
# endian_stream_ctrl

Byte-stream-to-word sequencer for the Ethernet receive path of the DCT offload. It accepts one byte per cycle from the MAC receive stream and packs bytes into `INPUT_BYTES`-wide words. Per packet, it either keeps network byte order or reverses it through the `endian_switch` datapath. It then presents each word, with byte-keep and last flags, on a valid/ready interface to the DCT input buffer.

## Interface
- `BYTE_SIZE`, 8, bits per byte lane.
- `INPUT_BYTES`, 4, byte lanes per output word (≥2).
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  `BYTE_SIZE`  input byte.
- `s_valid`  in  1  input byte valid.
- `s_ready`  out  1  block accepts byte; handshake = `s_valid & s_ready`.
- `s_last`  in  1  byte is the final byte of its packet.
- `swap_en`  in  1  byte-order select, sampled on the first byte of each packet.
- `m_data`  out  `INPUT_BYTES*BYTE_SIZE`  packed output word.
- `m_keep`  out  `INPUT_BYTES`  per-lane valid flag, one bit per byte lane.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts word.
- `m_last`  out  1  word carries the packet's final byte.
- `pkt_count`  out  16  completed packets; present only with `ENDIAN_CTRL_STATS_EN`.
- `word_count`  out  32  output words transferred; present only with `ENDIAN_CTRL_STATS_EN`.

## Operation
- **States:**
  - `IDLE`: no packet in progress.
  - `ACCUM`: lanes are being filled.
  - `STALL`: a complete word is held in the accumulator and the output register is occupied.
- **s_ready:** `s_ready = (state != STALL)`. It has no combinational path from `m_ready`.
- **Byte placement, `swap_en`=0:** the first byte of a word goes to the most significant lane (bits `[INPUT_BYTES*BYTE_SIZE-1 -: BYTE_SIZE]`). Later bytes fill progressively lower lanes.
- **Byte placement, `swap_en`=1:** the assembled word and its keep vector both pass through `endian_switch`, so the first byte lands in lane 0.
- **Latching `swap_en`:** it is captured on the handshake of a packet's first byte (`IDLE`→`ACCUM`). Changes while a packet is in progress are ignored.
- **Completing byte:** the byte that fills lane `INPUT_BYTES-1`, or any byte carrying `s_last`.
  - **Output free** (`!m_valid`, or `m_valid & m_ready` this cycle): the word goes straight into the output register on the same edge. The lane counter clears.
  - **Output busy:** the word is stored in the accumulator and the state goes to `STALL`.
- **Leaving STALL:** on the first `m_valid & m_ready` edge, the accumulator moves to the output register. The next state is `ACCUM`, or `IDLE` if the stored word had last set.
- **Partial last word:** unfilled lanes are zero and their keep bits are 0.
- **After s_last:** the next state is `IDLE`; the next accepted byte starts a new packet.
- **Output stability:** while `m_valid & !m_ready`, `m_data`, `m_keep` and `m_last` hold stable.
- **Output clear:** on an output handshake with nothing new to load, `m_valid` falls and `m_data`/`m_keep`/`m_last` hold their last values.

## Timing
- **Reset values:** `m_valid`=0, `m_data`=0, `m_keep`=0, `m_last`=0, state `IDLE`, so `s_ready`=1. Counters are 0.
- **Latency:** `m_valid` rises in the cycle after the completing byte's handshake edge.
- **Throughput:** one byte per cycle is sustained while `m_ready` stays high. Back-to-back packets need no gap cycles.
- **Simultaneous output handshake and completing byte:** the output register reloads on that edge and `m_valid` stays high.
- **Reset mid-packet:** the partial word and any held word are discarded and no output is produced. The next packet after reset is assembled correctly.
- **Single-byte packet:** produces one word with `m_keep` = the MSB lane only (swap 0) or lane 0 only (swap 1), and `m_last`=1.

## Configuration
- **`ENDIAN_CTRL_STATS_EN` defined:**
  - `word_count` increments on every output handshake.
  - `pkt_count` increments on every output handshake with `m_last`=1.
  - Both wrap modulo 2^width and reset to 0.
- **Undefined:** the counters and both ports are absent. Datapath behaviour is identical.

## Structure
- **Package `endian_ctrl_pkg`:**
  - state enum `{IDLE, ACCUM, STALL}`;
  - default `BYTE_SIZE`/`INPUT_BYTES`;
  - lane-counter width, `$clog2(INPUT_BYTES)`;
  - counter widths 16/32.
- **Sub-module:** `endian_switch`, instantiated twice.
  - Data path: `BYTE_SIZE`, `INPUT_BYTES`.
  - Keep path: `BYTE_SIZE`=1, `INPUT_BYTES`.
  - The swap mux selects between the straight and swapped outputs using the latched `swap_en`.

## Test plan
1. **Full word, no swap:** `swap_en`=0, bytes 11,22,33,44 (last on 44), `m_ready`=1 → `m_data`=32'h11223344, `m_keep`=4'hF, `m_last`=1, `m_valid` one cycle after the 44 handshake.
2. **Full word, swap:** same stimulus with `swap_en`=1 → `m_data`=32'h44332211, `m_keep`=4'hF.
3. **Partial last word:** 6-byte packet AA..FF.
   - `swap_en`=0 → words 32'hAABBCCDD/F/last0, then 32'hEEFF0000/4'hC/last1.
   - `swap_en`=1 → 32'hDDCCBBAA/F, then 32'h0000FFEE/4'h3/last1.
4. **Backpressure:** `m_ready`=0, stream 8 bytes 01..08 → `m_data`=32'h01020304 held stable; `s_ready` falls after byte 08 is accepted. Raise `m_ready` → 32'h01020304 handshakes, then 32'h05060708 appears next cycle, `s_ready`=1. No byte is lost or duplicated.
5. **Mid-packet swap change:** `swap_en` toggled 0→1 after the first byte of an 8-byte packet → both words are in unswapped order. The next packet uses `swap_en`=1.
6. **Reset mid-packet:** assert `rst_n`=0 after 3 bytes → all outputs 0, `s_ready`=1. A following packet 11,22,33,44 outputs 32'h11223344 correctly.
   - With `ENDIAN_CTRL_STATS_EN`: after cases 1–3, `pkt_count`=4 and `word_count`=6.
